// File: rtl/cnt_seq.sv
// Start/stop/clear sequencer around a W-bit modulo up-counter with single-shot or auto-reload.
// Optional prescaler on the advance tick is enabled by defining CNT_SEQ_PRESCALE_EN.
module cnt_seq #(
  parameter int W   = 8,
  parameter int PRE = 1
) (
  input  logic         Clk,
  input  logic         MR,
  input  logic         Start,
  input  logic         Stop,
  input  logic         Clear,
  input  logic         Auto,
  input  logic [W-1:0] Len,
  output logic [W-1:0] Q,
  output logic         C,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

  state_t       state_r, state_s;
  logic [W-1:0] q_r, q_s;
  logic [W-1:0] m_r, m_s;
  logic [W-1:0] last_s;
  logic         tick_s;
  logic         c_r, busy_r, done_r;
  logic         c_s, busy_s, done_s;

  // Modulus minus one wraps to all-ones when M=0, giving N=2^W.
  assign last_s = m_r - ONE_C;

`ifdef CNT_SEQ_PRESCALE_EN
  localparam logic [15:0] PRE_LAST_C = 16'(PRE - 1);

  logic [15:0] pre_r, pre_s;

  assign tick_s = (pre_r == PRE_LAST_C);

  // Prescaler next value: cleared on abort or fresh start, frozen outside active RUN.
  always_comb begin
    pre_s = pre_r;
    if (Clear) begin
      pre_s = 16'd0;
    end else if ((state_r == RUN) && !Stop) begin
      if (tick_s) begin
        pre_s = 16'd0;
      end else begin
        pre_s = pre_r + 16'd1;
      end
    end else if (((state_r == IDLE) || (state_r == DONE)) && Start) begin
      pre_s = 16'd0;
    end else begin
      pre_s = pre_r;
    end
  end

  // Prescaler register.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      pre_r <= 16'd0;
    end else begin
      pre_r <= pre_s;
    end
  end
`else
  // Without the prescaler every RUN edge advances; PRE only needs to be legal.
  assign tick_s = (PRE >= 1);
`endif

  // Next-state and next-count decode; Clear overrides everything.
  always_comb begin
    state_s = state_r;
    q_s     = q_r;
    m_s     = m_r;
    if (Clear) begin
      state_s = IDLE;
      q_s     = '0;
    end else begin
      case (state_r)
        IDLE: begin
          q_s = '0;
          if (Start) begin
            state_s = RUN;
            m_s     = Len;
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          if (Stop) begin
            state_s = PAUSE;
          end else if (tick_s) begin
            if (q_r == last_s) begin
              q_s     = '0;
              state_s = Auto ? RUN : DONE;
            end else begin
              q_s = q_r + ONE_C;
            end
          end else begin
            state_s = RUN;
          end
        end
        PAUSE: begin
          if (Start) begin
            state_s = RUN;
          end else begin
            state_s = PAUSE;
          end
        end
        DONE: begin
          q_s = '0;
          if (Start) begin
            state_s = RUN;
            m_s     = Len;
          end else begin
            state_s = IDLE;
          end
        end
        default: begin
          state_s = IDLE;
          q_s     = '0;
        end
      endcase
    end
  end

  // Flags are decoded from the next registered state so they match state/Q each cycle.
  always_comb begin
    c_s    = (state_s == RUN) && (q_s == (m_s - ONE_C));
    busy_s = (state_s == RUN) || (state_s == PAUSE);
    done_s = (state_s == DONE);
  end

  // State, count, modulus and flag registers.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state_r <= IDLE;
      q_r     <= '0;
      m_r     <= '0;
      c_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      q_r     <= q_s;
      m_r     <= m_s;
      c_r     <= c_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign Q    = q_r;
  assign C    = c_r;
  assign Busy = busy_r;
  assign Done = done_r;

endmodule
